// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte type, S-box size and the key-scheduling state encoding.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int SBOX_SIZE = 256;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RDI,
    LDI,
    RDJ,
    LDJ,
    WRI,
    WRJ
  } ksa_state_t;

  // Width of the key byte index; a one-byte key still needs a 1-bit index.
  function automatic int kidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_byte_sel.sv
// Combinational key byte select; key byte 0 is the most significant byte of key.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int KIDX_W    = kidx_width(KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KIDX_W-1:0]      kidx,
  output byte_t                  kbyte
);

  always_comb begin
    kbyte = key[8*KEY_BYTES-1 -: 8];
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIDX_W'(b)) kbyte = key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

endmodule

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes S in place through a single-port memory.
// Build option: define KSA_INIT_EN to fill S with the identity before scheduling.
module ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int                KIDX_W    = kidx_width(KEY_BYTES);
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  ksa_state_t               state;
  byte_t                    i;
  byte_t                    j;
  byte_t                    si;
  byte_t                    sj;
  byte_t                    kbyte;
  logic [KIDX_W-1:0]        kidx;
  logic [8*KEY_BYTES-1:0]   key_r;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_byte_sel (
    .key   (key_r),
    .kidx  (kidx),
    .kbyte (kbyte)
  );

  // i==255 is the terminal compare, so the 8-bit wrap of i never re-enters the loop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            key_r <= key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
`ifdef KSA_INIT_EN
            state <= INIT;
`else
            state <= RDI;
`endif
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) state <= RDI;
        end
        RDI: state <= LDI;
        LDI: begin
          si    <= rddata;
          j     <= j + rddata + kbyte;
          state <= RDJ;
        end
        RDJ: state <= LDJ;
        LDJ: begin
          sj    <= rddata;
          state <= WRI;
        end
        WRI: state <= WRJ;
        WRJ: begin
          i     <= i + 8'd1;
          kidx  <= (kidx == KIDX_LAST) ? '0 : kidx + KIDX_W'(1);
          state <= (i == 8'hFF) ? IDLE : RDI;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdy    = (state == IDLE);
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    case (state)
      INIT: begin
        addr   = i;
        wrdata = i;
        wren   = 1'b1;
      end
      RDI: addr = i;
      RDJ: addr = j;
      WRI: begin
        addr   = i;
        wrdata = sj;
        wren   = 1'b1;
      end
      WRJ: begin
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa with a behavioural S memory and a software RC4 KSA model.
module tb_ksa;

  localparam int KEY_BYTES = 3;
`ifdef KSA_INIT_EN
  localparam int RUN_CYC = 1792;
  localparam int INIT_W  = 256;
`else
  localparam int RUN_CYC = 1536;
  localparam int INIT_W  = 0;
`endif
  localparam int RUN_WR = 512 + INIT_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] key;
  logic        rdy;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  always #5 clk = ~clk;

  ksa #(.KEY_BYTES(KEY_BYTES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // Single-port synchronous memory, read-old-data, with a bulk preload port.
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_req = 1'b0;
  int         wcount = 0;
  logic [7:0] wlog_a [$];
  logic [7:0] wlog_d [$];

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= img[k];
    end else if (wren) begin
      mem[addr] <= wrdata;
      wcount    <= wcount + 1;
      wlog_a.push_back(addr);
      wlog_d.push_back(wrdata);
    end
    rddata <= mem[addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_s [256];

  task automatic preload(input bit fill_ff);
    for (int k = 0; k < 256; k++) img[k] = fill_ff ? 8'hFF : 8'(k);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic model_identity();
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
  endtask

  // Textbook RC4 key schedule applied to exp_s in place.
  task automatic model_ksa(input logic [23:0] k);
    int         jj;
    logic [7:0] t;
    logic [7:0] kb;
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = k[8*(KEY_BYTES-1-(ii % KEY_BYTES)) +: 8];
      jj = (jj + int'(exp_s[ii]) + int'(kb)) % 256;
      t = exp_s[ii];
      exp_s[ii] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  function automatic int count_diff();
    int d;
    d = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) d++;
    return d;
  endfunction

  // Start a run and count negedges with rdy low; bounded at 4000.
  task automatic run(input logic [23:0] k, input bit hold, output int cycles);
    @(negedge clk);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    if (!hold) en = 1'b0;
    cycles = 0;
    while (rdy === 1'b0 && cycles < 4000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 1'b0;
    en    = 1'b0;
    key   = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", rdy); end
    n_tests++;
    if (wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", wren); end
    n_tests++;
    if (addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", addr); end
    rst_n = 1'b1;
    w0 = wcount;
    repeat (20) @(negedge clk);
    n_tests++;
    if (wcount !== w0) begin n_fail++; $display("FAIL idle_writes got %0d want %0d", wcount, w0); end
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL idle_rdy got %b want 1", rdy); end
  endtask

  task automatic test_zero_key();
    int         base;
    int         cyc;
    int         d;
    logic [7:0] ea [6];
    logic [7:0] ed [6];
    ea = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    ed = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
    preload(1'b0);
    base = wlog_a.size();
    run(24'h000000, 1'b0, cyc);
    n_tests++;
    if (cyc != RUN_CYC) begin n_fail++; $display("FAIL zero_latency got %0d want %0d", cyc, RUN_CYC); end
    n_tests++;
    if (wlog_a.size() - base != RUN_WR) begin
      n_fail++;
      $display("FAIL zero_wcount got %0d want %0d", wlog_a.size() - base, RUN_WR);
    end
    for (int n = 0; n < 6; n++) begin
      n_tests++;
      if (base + INIT_W + n >= wlog_a.size()) begin
        n_fail++;
        $display("FAIL zero_write%0d missing", n);
      end else if (wlog_a[base+INIT_W+n] !== ea[n] || wlog_d[base+INIT_W+n] !== ed[n]) begin
        n_fail++;
        $display("FAIL zero_write%0d got S[%0d]=%0d want S[%0d]=%0d", n,
                 wlog_a[base+INIT_W+n], wlog_d[base+INIT_W+n], ea[n], ed[n]);
      end
    end
    model_identity();
    model_ksa(24'h000000);
    d = count_diff();
    n_tests++;
    if (d != 0) begin n_fail++; $display("FAIL zero_final_s got %0d bytes differing want 0", d); end
  endtask

  task automatic test_random_keys();
    logic [23:0] k;
    int          cyc;
    int          d;
    for (int r = 0; r < 4; r++) begin
      k = (r == 0) ? 24'h000018 : 24'($urandom());
      preload(1'b0);
      run(k, 1'b0, cyc);
      n_tests++;
      if (cyc != RUN_CYC) begin
        n_fail++;
        $display("FAIL key_latency key=%h got %0d want %0d", k, cyc, RUN_CYC);
      end
      model_identity();
      model_ksa(k);
      d = count_diff();
      n_tests++;
      if (d != 0) begin n_fail++; $display("FAIL key_final_s key=%h got %0d bytes differing want 0", k, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] k;
    int          cyc;
    int          d;
    k = 24'($urandom());
    preload(1'b0);
    run(k, 1'b1, cyc);
    n_tests++;
    if (cyc != RUN_CYC) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", cyc, RUN_CYC); end
    model_identity();
    model_ksa(k);
    d = count_diff();
    n_tests++;
    if (d != 0) begin n_fail++; $display("FAIL b2b_first_s got %0d bytes differing want 0", d); end
    // en is still high, so the very next edge accepts a second run.
    @(negedge clk);
    en = 1'b0;
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got rdy=%b want 0", rdy); end
    cyc = 1;
    while (rdy === 1'b0 && cyc < 4000) begin
      @(negedge clk);
      if (rdy === 1'b0) cyc++;
    end
    n_tests++;
    if (cyc != RUN_CYC) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", cyc, RUN_CYC); end
`ifdef KSA_INIT_EN
    model_identity();
`endif
    model_ksa(k);
    d = count_diff();
    n_tests++;
    if (d != 0) begin n_fail++; $display("FAIL b2b_second_s got %0d bytes differing want 0", d); end
  endtask

  task automatic test_abort();
    int w0;
    preload(1'b0);
    @(negedge clk);
    en  = 1'b1;
    key = 24'($urandom());
    @(negedge clk);
    en = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL abort_rdy got %b want 1", rdy); end
    n_tests++;
    if (wren !== 1'b0) begin n_fail++; $display("FAIL abort_wren got %b want 0", wren); end
    rst_n = 1'b1;
    w0 = wcount;
    repeat (30) @(negedge clk);
    n_tests++;
    if (wcount !== w0) begin n_fail++; $display("FAIL abort_writes got %0d want %0d", wcount, w0); end
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_rdy got %b want 1", rdy); end
  endtask

`ifdef KSA_INIT_EN
  task automatic test_init();
    int base;
    int cyc;
    int bad;
    int d;
    preload(1'b1);
    base = wlog_a.size();
    run(24'h000018, 1'b0, cyc);
    n_tests++;
    if (cyc != 1792) begin n_fail++; $display("FAIL init_latency got %0d want 1792", cyc); end
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (base + k >= wlog_a.size()) bad++;
      else if (wlog_a[base+k] !== 8'(k) || wlog_d[base+k] !== 8'(k)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL init_writes got %0d wrong want 0", bad); end
    model_identity();
    model_ksa(24'h000018);
    d = count_diff();
    n_tests++;
    if (d != 0) begin n_fail++; $display("FAIL init_final_s got %0d bytes differing want 0", d); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    key   = '0;
    test_reset();
    test_zero_key();
    test_random_keys();
    test_back_to_back();
    test_abort();
`ifdef KSA_INIT_EN
    test_init();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
